img_io_rx_ctrl_p: RTL and testbench

Parametrised successor to the image-load IO receiver. Accepts a row-major pixel stream over a valid/ready handshake and issues one SRAM write per accepted pixel. Supports two storage layouts, row-major and transposed (column-major), plus a programmable base address, so several frames or intermediate buffers can share one img_sram. Sits between the chip IO pad interface and the image SRAM mux, alongside the TX controller.

---
 rtl/img_io_rx_ctrl_p_if.sv | 35 +++
 rtl/img_io_rx_ctrl_p.sv | 133 +++++++++++++
 tb/tb_img_io_rx_ctrl_p.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/img_io_rx_ctrl_p_if.sv
// Pixel-receive interface for img_io_rx_ctrl_p: frame configuration and start/abort,
// the incoming pixel handshake, status, and the image SRAM write port.
interface img_io_rx_ctrl_p_if #(
   parameter int DATA_W = 8,
   parameter int ROW_W  = 8,
   parameter int COL_W  = 8,
   parameter int ADDR_W = 14
);
   logic              en;
   logic              abort;
   logic [ROW_W-1:0]  nrows;
   logic [COL_W-1:0]  ncols;
   logic              mode;
   logic [ADDR_W-1:0] base_addr;
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              busy;
   logic              done;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_din;

   // Pad-side controller that drives the frame and pixels.
   modport master (
      output en, abort, nrows, ncols, mode, base_addr, din, din_valid,
      input  din_ready, busy, done, sram_we, sram_addr, sram_din
   );

   // The receiver itself.
   modport slave (
      input  en, abort, nrows, ncols, mode, base_addr, din, din_valid,
      output din_ready, busy, done, sram_we, sram_addr, sram_din
   );
endinterface

// File: rtl/img_io_rx_ctrl_p.sv
// Image-load receiver: accepts a row-major pixel stream and writes each pixel to
// SRAM in row-major or transposed layout starting at a programmable base address.
// Addresses are generated incrementally (no multiplier) and wrap modulo 2^ADDR_W.
module img_io_rx_ctrl_p #(
   parameter int DATA_W = 8,
   parameter int ROW_W  = 8,
   parameter int COL_W  = 8,
   parameter int ADDR_W = 14
) (
   input logic               clk,
   input logic               rstn,
   img_io_rx_ctrl_p_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t            state_q, state_d;
   logic [ROW_W-1:0]  nrows_q, r_q;
   logic [COL_W-1:0]  ncols_q, c_q;
   logic              mode_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] row_start_q;
   logic              start_p0;
   logic              accept_p0;
   logic              last_col_p0;
   logic              last_row_p0;
   logic              vld_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic [DATA_W-1:0] din_p1;

   // Address sum that deliberately wraps to ADDR_W bits.
   function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
      return a + b;
   endfunction

   // abort outranks both a start request and pixel acceptance.
   assign start_p0    = (state_q == IDLE) && bus.en && !bus.abort;
   assign accept_p0   = (state_q == RECV) && bus.din_valid && !bus.abort;
   assign last_col_p0 = (c_q == ncols_q - COL_W'(1));
   assign last_row_p0 = (r_q == nrows_q - ROW_W'(1));

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state decode and status outputs.
   always_comb begin
      state_d       = state_q;
      bus.busy      = 1'b0;
      bus.din_ready = 1'b0;
      bus.done      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_p0) begin
               if ((bus.nrows == '0) || (bus.ncols == '0)) state_d = DONE;
               else                                      state_d = RECV;
            end
         end
         RECV: begin
            bus.busy      = 1'b1;
            bus.din_ready = 1'b1;
            if (accept_p0 && last_col_p0 && last_row_p0) state_d = DONE;
         end
         DONE: begin
            bus.done = !bus.abort;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (bus.abort) state_d = IDLE;
   end

   // Stage p0: frame configuration, pixel counters and incremental address.
   // Transposed layout steps by nrows along a row and restarts one past the
   // previous row's first address, tracked in row_start_q.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         nrows_q     <= '0;
         ncols_q     <= '0;
         mode_q      <= 1'b0;
         r_q         <= '0;
         c_q         <= '0;
         addr_q      <= '0;
         row_start_q <= '0;
      end else if (start_p0) begin
         nrows_q     <= bus.nrows;
         ncols_q     <= bus.ncols;
         mode_q      <= bus.mode;
         r_q         <= '0;
         c_q         <= '0;
         addr_q      <= bus.base_addr;
         row_start_q <= bus.base_addr;
      end else if (accept_p0) begin
         if (last_col_p0) begin
            c_q <= '0;
            r_q <= r_q + ROW_W'(1);
            if (mode_q) begin
               row_start_q <= wrap_add(row_start_q, ADDR_W'(1));
               addr_q      <= wrap_add(row_start_q, ADDR_W'(1));
            end else begin
               addr_q <= wrap_add(addr_q, ADDR_W'(1));
            end
         end else begin
            c_q    <= c_q + COL_W'(1);
            addr_q <= mode_q ? wrap_add(addr_q, ADDR_W'(nrows_q))
                             : wrap_add(addr_q, ADDR_W'(1));
         end
      end
   end

   // Stage p1: registered SRAM write; address and data hold when idle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_p1  <= 1'b0;
         addr_p1 <= '0;
         din_p1  <= '0;
      end else begin
         vld_p1 <= accept_p0;
         if (accept_p0) begin
            addr_p1 <= addr_q;
            din_p1  <= bus.din;
         end
      end
   end

   assign bus.sram_we   = vld_p1;
   assign bus.sram_addr = addr_p1;
   assign bus.sram_din  = din_p1;

endmodule

// File: tb/tb_img_io_rx_ctrl_p.sv
// Directed bench for img_io_rx_ctrl_p: row-major, transposed, gapped, empty,
// aborted and address-wrapping frames, with a write monitor on the SRAM port.
module tb_img_io_rx_ctrl_p;
   localparam int DATA_W = 8;
   localparam int ROW_W  = 8;
   localparam int COL_W  = 8;
   localparam int ADDR_W = 14;

   logic clk = 1'b0;
   logic rstn;

   always #5 clk = ~clk;

   img_io_rx_ctrl_p_if #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)) bus ();

   img_io_rx_ctrl_p #(.DATA_W(DATA_W), .ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Write monitor, sampled on the falling edge.
   logic [ADDR_W-1:0] waddr[$];
   logic [DATA_W-1:0] wdata[$];
   int                busy_cnt, done_cnt, bad_we;
   logic              done_we;
   logic [ADDR_W-1:0] done_addr;
   logic              acc_prev;

   always @(negedge clk) begin
      if (!rstn) begin
         acc_prev = 1'b0;
      end else begin
         if (bus.sram_we) begin
            waddr.push_back(bus.sram_addr);
            wdata.push_back(bus.sram_din);
            if (!acc_prev) bad_we++;
         end
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            done_we   = bus.sram_we;
            done_addr = bus.sram_addr;
         end
         acc_prev = bus.din_valid && bus.din_ready && !bus.abort;
      end
   end

   task automatic clr_mon();
      waddr.delete();
      wdata.delete();
      busy_cnt  = 0;
      done_cnt  = 0;
      bad_we    = 0;
      done_we   = 1'b0;
      done_addr = '0;
   endtask

   // Start a frame and stream npix pixels (din = pixel index).
   // gap!=0 drops din_valid on every third cycle; abort_after>0 aborts after
   // that many accepted pixels; en_at>0 re-pulses en (with a bogus nrows)
   // once that many pixels have been accepted.
   task automatic send_frame(input string tag, input int nr, input int nc, input int md,
                             input int base, input int npix, input int gap,
                             input int abort_after, input int en_at);
      int   i;
      int   k;
      int   budget;
      logic acc;
      i      = 0;
      k      = 0;
      budget = npix * 4 + 20;
      @(posedge clk); #1;
      bus.nrows     = ROW_W'(nr);
      bus.ncols     = COL_W'(nc);
      bus.mode      = md[0];
      bus.base_addr = ADDR_W'(base);
      bus.en        = 1'b1;
      bus.din       = '0;
      bus.din_valid = 1'b1;
      while (i < npix && k < budget) begin
         @(negedge clk);
         acc = bus.din_valid && bus.din_ready;
         @(posedge clk); #1;
         bus.en = 1'b0;
         k++;
         if (acc) i++;
         if (abort_after > 0 && i == abort_after) begin
            bus.abort     = 1'b1;
            bus.din_valid = 1'b0;
            @(posedge clk); #1;
            bus.abort = 1'b0;
            break;
         end
         if (en_at > 0 && i == en_at) begin
            bus.en    = 1'b1;
            bus.nrows = ROW_W'(9);
         end
         bus.din       = DATA_W'(i);
         bus.din_valid = (gap == 0) || ((k % 3) != 1);
      end
      bus.din_valid = 1'b0;
      bus.en        = 1'b0;
      if (abort_after == 0) chk({tag, "_accepted"}, i, npix);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int mism;
      int dmism;
      logic [ADDR_W-1:0] exp_a;
      int tr_addr [12];

      rstn          = 1'b0;
      bus.en        = 1'b0;
      bus.abort     = 1'b0;
      bus.nrows     = '0;
      bus.ncols     = '0;
      bus.mode      = 1'b0;
      bus.base_addr = '0;
      bus.din       = '0;
      bus.din_valid = 1'b0;
      clr_mon();

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",      bus.busy,      0);
      chk("rst_done",      bus.done,      0);
      chk("rst_we",        bus.sram_we,   0);
      chk("rst_addr",      bus.sram_addr, 0);
      chk("rst_din",       bus.sram_din,  0);
      chk("rst_din_ready", bus.din_ready, 0);
      @(posedge clk); #1;
      rstn = 1'b1;

      // Row-major 128x128, continuous stream.
      clr_mon();
      send_frame("rm128", 128, 128, 0, 0, 16384, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("rm128_writes", waddr.size(), 16384);
      mism  = 0;
      dmism = 0;
      foreach (waddr[j]) begin
         if (waddr[j] !== ADDR_W'(j)) mism++;
         if (wdata[j] !== DATA_W'(j)) dmism++;
      end
      chk("rm128_addr_mism", mism, 0);
      chk("rm128_data_mism", dmism, 0);
      chk("rm128_busy_cycles", busy_cnt, 16384);
      chk("rm128_done_cnt", done_cnt, 1);
      chk("rm128_done_with_we", done_we, 1);
      chk("rm128_done_addr", done_addr, 16383);

      // Transposed 4x3 at base 0x100.
      tr_addr = '{'h100, 'h104, 'h108, 'h101, 'h105, 'h109,
                  'h102, 'h106, 'h10A, 'h103, 'h107, 'h10B};
      clr_mon();
      send_frame("tr43", 4, 3, 1, 'h100, 12, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("tr43_writes", waddr.size(), 12);
      for (int j = 0; j < 12; j++) begin
         chk($sformatf("tr43_addr%0d", j), (j < waddr.size()) ? 32'(waddr[j]) : 32'hFFFF_FFFF,
             tr_addr[j]);
         chk($sformatf("tr43_data%0d", j), (j < wdata.size()) ? 32'(wdata[j]) : 32'hFFFF_FFFF, j);
      end
      chk("tr43_done_cnt", done_cnt, 1);

      // Row-major 8x8 with valid gaps.
      clr_mon();
      send_frame("gap88", 8, 8, 0, 0, 64, 1, 0, 0);
      repeat (3) @(negedge clk);
      chk("gap88_writes", waddr.size(), 64);
      mism = 0;
      foreach (waddr[j]) if (waddr[j] !== ADDR_W'(j)) mism++;
      chk("gap88_addr_mism", mism, 0);
      chk("gap88_spurious_we", bad_we, 0);
      chk("gap88_done_cnt", done_cnt, 1);

      // Empty frame: nrows=0.
      clr_mon();
      @(posedge clk); #1;
      bus.nrows = '0;
      bus.ncols = COL_W'(5);
      bus.en    = 1'b1;
      @(posedge clk); #1;
      bus.en = 1'b0;
      @(negedge clk);
      chk("zero_done_now", bus.done, 1);
      repeat (4) @(negedge clk);
      chk("zero_writes", waddr.size(), 0);
      chk("zero_busy_cycles", busy_cnt, 0);
      chk("zero_done_cnt", done_cnt, 1);

      // Abort after 10 pixels of 16x16, then a clean 2x2 frame.
      clr_mon();
      send_frame("abort", 16, 16, 0, 0, 256, 0, 10, 0);
      repeat (4) @(negedge clk);
      chk("abort_writes", waddr.size(), 10);
      chk("abort_done_cnt", done_cnt, 0);
      chk("abort_busy_now", bus.busy, 0);
      chk("abort_ready_now", bus.din_ready, 0);
      clr_mon();
      send_frame("post_abort", 2, 2, 0, 'h20, 4, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("post_abort_writes", waddr.size(), 4);
      for (int j = 0; j < 4; j++)
         chk($sformatf("post_abort_addr%0d", j),
             (j < waddr.size()) ? 32'(waddr[j]) : 32'hFFFF_FFFF, 'h20 + j);
      chk("post_abort_done_cnt", done_cnt, 1);

      // Base near the top of the address space, en re-pulsed mid-frame.
      clr_mon();
      send_frame("wrap", 2, 2, 0, 'h3FFE, 4, 0, 0, 1);
      repeat (4) @(negedge clk);
      chk("wrap_writes", waddr.size(), 4);
      for (int j = 0; j < 4; j++) begin
         exp_a = ADDR_W'('h3FFE + j);
         chk($sformatf("wrap_addr%0d", j),
             (j < waddr.size()) ? 32'(waddr[j]) : 32'hFFFF_FFFF, exp_a);
      end
      chk("wrap_done_cnt", done_cnt, 1);
      chk("wrap_idle_busy", bus.busy, 0);
      chk("wrap_busy_cycles", busy_cnt, 4);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
